// File: rtl/instr_sequencer_if.sv
// ALU-side handshake bundle for instr_sequencer: issued opcode/immediate with
// valid/ready, plus the ALU status flags returned for conditional branches.
interface instr_sequencer_if;
   logic [7:0]  alu_opcode;
   logic [31:0] alu_val;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  flags;

   modport master (
      output alu_opcode, alu_val, alu_valid,
      input  alu_ready, flags
   );

   modport slave (
      input  alu_opcode, alu_val, alu_valid,
      output alu_ready, flags
   );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode sequencer: runs control flow locally and issues ALU ops.
// Optional return stack enabled by defining SEQ_RSTACK_EN.
//
// state  | meaning
// IDLE   | stopped, program memory writable, waits for run
// FETCH  | instr <= mem[pc]
// DECODE | execute control op or latch ALU op; flags sampled here
// ISSUE  | alu_valid high, waits for alu_ready
// HALT   | HALT executed, memory writable, waits for run=0
// FAULT  | illegal stack use, left only by reset
module instr_sequencer #(
   parameter int ISIZE     = 32,
   parameter int IPTR_SIZE = 4,
   parameter int RS_DEPTH  = 4
) (
   input  logic                 clkout,
   input  logic                 rst_n,
   input  logic                 load_en,
   input  logic [IPTR_SIZE-1:0] load_addr,
   input  logic [ISIZE-1:0]     load_data,
   input  logic                 run,
   instr_sequencer_if.master    alu,
   output logic [IPTR_SIZE-1:0] pc,
   output logic                 halted,
   output logic                 fault,
   output logic                 stack_ovf,
   output logic                 stack_unf
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALT, S_FAULT
   } state_t;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_JMP  = 8'hF0;
   localparam logic [7:0] OP_JMR  = 8'hF1;
   localparam logic [7:0] OP_CALL = 8'hF2;
   localparam logic [7:0] OP_RET  = 8'hF3;
   localparam logic [7:0] OP_HALT = 8'hFF;

   localparam logic [IPTR_SIZE-1:0] PC_ONE = IPTR_SIZE'(1);

   state_t               state_q;
   logic [IPTR_SIZE-1:0] pc_q;
   logic [ISIZE-1:0]     instr_q;
   logic [7:0]           alu_opcode_q;
   logic [31:0]          alu_val_q;
   logic                 alu_valid_q;
   logic                 halted_q;
   logic                 fault_q;
   logic [ISIZE-1:0]     mem_q [2**IPTR_SIZE];

   logic [7:0]           opcode;
   logic [15:0]          imm;
   logic [IPTR_SIZE-1:0] imm_pc;
   logic [IPTR_SIZE-1:0] pc_inc;
   logic                 cond_ok;

`ifdef SEQ_RSTACK_EN
   localparam int SP_W = $clog2(RS_DEPTH + 1);
   localparam int SI_W = $clog2(RS_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(RS_DEPTH);

   logic [SP_W-1:0]      sp_q;
   logic [SP_W-1:0]      sp_dec;
   logic [IPTR_SIZE-1:0] stack_q [RS_DEPTH];
   logic                 stack_ovf_q;
   logic                 stack_unf_q;

   assign sp_dec    = sp_q - SP_ONE;
   assign stack_ovf = stack_ovf_q;
   assign stack_unf = stack_unf_q;
`else
   assign stack_ovf = 1'b0;
   assign stack_unf = 1'b0;
`endif

   assign opcode = instr_q[31:24];
   assign imm    = instr_q[15:0];
   assign imm_pc = instr_q[IPTR_SIZE-1:0];
   assign pc_inc = pc_q + PC_ONE;

   // Condition order matches the flag vector {Z, C, S, P, V}.
   always_comb begin
      cond_ok = 1'b0;
      case (instr_q[23:21])
         3'b000:  cond_ok = 1'b1;
         3'b001:  cond_ok = alu.flags[4];
         3'b010:  cond_ok = alu.flags[3];
         3'b011:  cond_ok = alu.flags[2];
         3'b100:  cond_ok = alu.flags[1];
         3'b101:  cond_ok = alu.flags[0];
         default: cond_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clkout) begin
      if (load_en && (state_q == S_IDLE || state_q == S_HALT))
         mem_q[load_addr] <= load_data;
   end

   always_ff @(posedge clkout) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         instr_q      <= '0;
         alu_opcode_q <= '0;
         alu_val_q    <= '0;
         alu_valid_q  <= 1'b0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
`ifdef SEQ_RSTACK_EN
         sp_q         <= '0;
         stack_ovf_q  <= 1'b0;
         stack_unf_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (run) state_q <= S_FETCH;
            S_FETCH: begin
               instr_q <= mem_q[pc_q];
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               state_q <= S_FETCH;
               case (opcode)
                  OP_NOP: pc_q <= pc_inc;
                  OP_HALT: begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end
                  OP_JMP: pc_q <= cond_ok ? imm_pc : pc_inc;
                  OP_JMR: pc_q <= cond_ok ? pc_q + imm_pc : pc_inc;
`ifdef SEQ_RSTACK_EN
                  OP_CALL: begin
                     if (!cond_ok) begin
                        pc_q <= pc_inc;
                     end else if (sp_q == SP_FULL) begin
                        stack_ovf_q <= 1'b1;
                        fault_q     <= 1'b1;
                        state_q     <= S_FAULT;
                     end else begin
                        stack_q[sp_q[SI_W-1:0]] <= pc_inc;
                        sp_q <= sp_q + SP_ONE;
                        pc_q <= imm_pc;
                     end
                  end
                  OP_RET: begin
                     if (!cond_ok) begin
                        pc_q <= pc_inc;
                     end else if (sp_q == '0) begin
                        stack_unf_q <= 1'b1;
                        fault_q     <= 1'b1;
                        state_q     <= S_FAULT;
                     end else begin
                        pc_q <= stack_q[sp_dec[SI_W-1:0]];
                        sp_q <= sp_dec;
                     end
                  end
`else
                  // Without a stack, CALL/RET are illegal whatever their condition.
                  OP_CALL, OP_RET: begin
                     fault_q <= 1'b1;
                     state_q <= S_FAULT;
                  end
`endif
                  default: begin
                     alu_opcode_q <= opcode;
                     alu_val_q    <= {{16{imm[15]}}, imm};
                     alu_valid_q  <= 1'b1;
                     state_q      <= S_ISSUE;
                  end
               endcase
            end
            S_ISSUE: begin
               if (alu.alu_ready) begin
                  alu_valid_q <= 1'b0;
                  pc_q        <= pc_inc;
                  state_q     <= S_FETCH;
               end
            end
            S_HALT: begin
               if (!run) begin
                  pc_q     <= '0;
                  halted_q <= 1'b0;
                  state_q  <= S_IDLE;
               end
            end
            S_FAULT: state_q <= S_FAULT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Condition bits of ALU ops and the reserved field are deliberately unused.
   logic unused_ok;
   assign unused_ok = &{1'b0, instr_q[20:16], RS_DEPTH[0]};

   assign alu.alu_opcode = alu_opcode_q;
   assign alu.alu_val    = alu_val_q;
   assign alu.alu_valid  = alu_valid_q;
   assign pc             = pc_q;
   assign halted         = halted_q;
   assign fault          = fault_q;

endmodule
